// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the exec sequencer: FSM states, opcode classes,
// instruction field positions and small field-extraction helpers.
package exec_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_LOAD  = 5'b10100;
  localparam logic [4:0] OP_STORE = 5'b10101;
  localparam logic [4:0] OP_JMP   = 5'b11000;
  localparam logic [4:0] OP_BZ    = 5'b11001;
  localparam logic [4:0] OP_HLT   = 5'b11111;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;
  localparam int RD_MSB  = 10;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 5;
  localparam int RT_MSB  = 4;
  localparam int RT_LSB  = 2;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam int Z_FLAG = 0;

  function automatic logic [4:0] get_opcode(input logic [15:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [2:0] get_rd(input logic [15:0] instr);
    return instr[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [2:0] get_rs(input logic [15:0] instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [2:0] get_rt(input logic [15:0] instr);
    return instr[RT_MSB:RT_LSB];
  endfunction

  function automatic logic [7:0] get_imm(input logic [15:0] instr);
    return instr[IMM_MSB:IMM_LSB];
  endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Bundle between the sequencer and the execution datapath / data memory.
interface exec_sequencer_if;

  logic [4:0] op_dec;
  logic [2:0] rd_addr;
  logic [2:0] rs_addr;
  logic [2:0] rt_addr;
  logic [7:0] imm;
  logic       rf_we;
  logic [3:0] flag_ex;
  logic       dm_req;
  logic       dm_we;
  logic       dm_ready;

  modport master (
    output op_dec, rd_addr, rs_addr, rt_addr, imm, rf_we, dm_req, dm_we,
    input  flag_ex, dm_ready
  );

  modport slave (
    input  op_dec, rd_addr, rs_addr, rt_addr, imm, rf_we, dm_req, dm_we,
    output flag_ex, dm_ready
  );

endinterface

// File: rtl/exec_ctrl_decode.sv
// Combinational opcode-class decoder; anything not a named class is an ALU op.
module exec_ctrl_decode
  import exec_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output logic       is_alu,
  output logic       is_load,
  output logic       is_store,
  output logic       is_jmp,
  output logic       is_bz,
  output logic       is_nop,
  output logic       is_hlt
);

  always_comb begin
    is_nop   = (opcode == OP_NOP);
    is_load  = (opcode == OP_LOAD);
    is_store = (opcode == OP_STORE);
    is_jmp   = (opcode == OP_JMP);
    is_bz    = (opcode == OP_BZ);
    is_hlt   = (opcode == OP_HLT);
    is_alu   = !(is_nop || is_load || is_store || is_jmp || is_bz || is_hlt);
  end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: owns PC, IR, latched ALU flags,
// memory timeout counter and the registered control outputs.
module exec_sequencer
  import exec_ctrl_pkg::*;
#(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter int         MEM_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             instr_in,
  output logic [7:0]              pc_out,
  exec_sequencer_if.master        bus,
  output logic                    halted,
  output logic                    fault
);

  localparam logic [7:0] MEM_LIMIT = 8'(MEM_TIMEOUT - 1);

  state_t      state;
  state_t      next_state;
  logic [7:0]  pc;
  logic [7:0]  pc_next;
  logic [15:0] ir;
  logic [3:0]  flags;
  logic [7:0]  tmo_cnt;
  logic        mem_timeout;

  logic [4:0]  ir_opcode;
  logic [7:0]  ir_imm;

  logic        is_alu, is_load, is_store, is_jmp, is_bz, is_nop, is_hlt;

  logic [4:0]  op_dec_d, op_dec_q;
  logic        rf_we_d, rf_we_q;
  logic        dm_req_d, dm_req_q;
  logic        dm_we_d, dm_we_q;
  logic        halted_d, halted_q;
  logic        fault_d, fault_q;

  logic        unused_flags;

  assign ir_opcode = get_opcode(ir);
  assign ir_imm    = get_imm(ir);

  exec_ctrl_decode u_decode (
    .opcode   (ir_opcode),
    .is_alu   (is_alu),
    .is_load  (is_load),
    .is_store (is_store),
    .is_jmp   (is_jmp),
    .is_bz    (is_bz),
    .is_nop   (is_nop),
    .is_hlt   (is_hlt)
  );

  // Only Z drives branching; the upper flag bits are latched for completeness.
  assign unused_flags = ^flags[3:1];

  assign mem_timeout = (tmo_cnt == MEM_LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:     next_state = S_DECODE;
      S_DECODE: begin
        if (is_nop) begin
          next_state = S_FETCH;
        end else if (is_hlt) begin
          next_state = S_HALT;
        end else begin
          next_state = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (is_alu) begin
          next_state = S_WRITEBACK;
        end else if (is_load || is_store) begin
          next_state = S_MEM;
        end else begin
          next_state = S_FETCH;
        end
      end
      // A ready strobe on the final allowed cycle still completes the access.
      S_MEM: begin
        if (bus.dm_ready) begin
          next_state = is_load ? S_WRITEBACK : S_FETCH;
        end else if (mem_timeout) begin
          next_state = S_HALT;
        end
      end
      S_WRITEBACK: next_state = S_FETCH;
      S_HALT:      next_state = S_HALT;
      default:     next_state = S_FETCH;
    endcase
  end

  always_comb begin
    pc_next = pc;
    case (state)
      S_FETCH:   pc_next = pc + 8'd1;
      S_EXECUTE: begin
        if (is_jmp || (is_bz && flags[Z_FLAG])) begin
          pc_next = ir_imm;
        end
      end
      default:   pc_next = pc;
    endcase
  end

  // Outputs are registered from the upcoming state so they line up with it.
  always_comb begin
    op_dec_d = (next_state == S_EXECUTE) ? ir_opcode : OP_NOP;
    rf_we_d  = (next_state == S_WRITEBACK);
    dm_req_d = (next_state == S_MEM);
    dm_we_d  = (next_state == S_MEM) && is_store;
    halted_d = (next_state == S_HALT);
    fault_d  = fault_q || ((state == S_MEM) && (next_state == S_HALT));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      ir       <= '0;
      flags    <= '0;
      tmo_cnt  <= '0;
      op_dec_q <= '0;
      rf_we_q  <= 1'b0;
      dm_req_q <= 1'b0;
      dm_we_q  <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      pc <= pc_next;
      if (state == S_FETCH) begin
        ir <= instr_in;
      end
      if ((state == S_EXECUTE) && is_alu) begin
        flags <= bus.flag_ex;
      end
      tmo_cnt  <= (state == S_MEM) ? (tmo_cnt + 8'd1) : 8'd0;
      op_dec_q <= op_dec_d;
      rf_we_q  <= rf_we_d;
      dm_req_q <= dm_req_d;
      dm_we_q  <= dm_we_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  assign pc_out      = pc;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign bus.op_dec  = op_dec_q;
  assign bus.rf_we   = rf_we_q;
  assign bus.dm_req  = dm_req_q;
  assign bus.dm_we   = dm_we_q;
  assign bus.rd_addr = get_rd(ir);
  assign bus.rs_addr = get_rs(ir);
  assign bus.rt_addr = get_rt(ir);
  assign bus.imm     = ir_imm;

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench: an instruction-level model expands each instruction into
// its expected per-cycle output trace, which is compared against the sequencer.
module tb_exec_sequencer;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instr_in;
  logic [7:0]  pc_out;
  logic        halted;
  logic        fault;
  logic [15:0] rom [256];

  exec_sequencer_if bus ();

  exec_sequencer #(.RESET_PC(8'h00), .MEM_TIMEOUT(T)) dut (
    .clk      (clk),
    .reset    (reset),
    .instr_in (instr_in),
    .pc_out   (pc_out),
    .bus      (bus),
    .halted   (halted),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  assign instr_in = rom[pc_out];

  typedef struct packed {
    logic [3:0] flag;
    logic       rdy;
    logic [7:0] pc;
    logic [4:0] op;
    logic       rf_we;
    logic [2:0] rd;
    logic       dm_req;
    logic       dm_we;
    logic       halted;
    logic       fault;
  } cyc_t;

  cyc_t trace[$];
  int   tests = 0;
  int   fails = 0;
  int   force_lat = 0;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // 0 alu, 1 nop, 2 load, 3 store, 4 jmp, 5 bz, 6 hlt
  function automatic int op_class(input logic [4:0] opc);
    case (opc)
      5'b00000: return 1;
      5'b10100: return 2;
      5'b10101: return 3;
      5'b11000: return 4;
      5'b11001: return 5;
      5'b11111: return 6;
      default:  return 0;
    endcase
  endfunction

  function automatic logic [15:0] rand_instr();
    int         sel;
    logic [4:0] opc;
    logic [10:0] rest;
    sel  = $urandom_range(0, 99);
    rest = 11'($urandom);
    if (sel < 10)      opc = 5'b00000;
    else if (sel < 22) opc = 5'b10100;
    else if (sel < 34) opc = 5'b10101;
    else if (sel < 44) opc = 5'b11000;
    else if (sel < 56) opc = 5'b11001;
    else if (sel < 58) opc = 5'b11111;
    else begin
      opc = 5'($urandom_range(1, 30));
      while (op_class(opc) != 0) opc = 5'($urandom_range(1, 30));
    end
    return {opc, rest};
  endfunction

  function automatic int pick_latency();
    int s;
    if (force_lat != 0) return force_lat;
    s = $urandom_range(0, 9);
    case (s)
      6:       return T;
      7:       return T - 1;
      8:       return T + 1;
      9:       return $urandom_range(1, T);
      default: return $urandom_range(1, 4);
    endcase
  endfunction

  function automatic cyc_t idle_cycle(input logic [7:0] pc);
    cyc_t c;
    c        = '0;
    c.pc     = pc;
    c.flag   = 4'($urandom);
    c.rdy    = ($urandom_range(0, 3) == 0);
    return c;
  endfunction

  task automatic push_halt(input logic [7:0] pc, input logic flt);
    for (int k = 0; k < 5; k++) begin
      cyc_t c;
      c        = idle_cycle(pc);
      c.halted = 1'b1;
      c.fault  = flt;
      trace.push_back(c);
    end
  endtask

  task automatic gen_trace(input int max_cycles);
    logic [7:0] m_pc;
    logic       m_z;
    bit         stop;
    m_pc = 8'h00;
    m_z  = 1'b0;
    stop = 0;
    trace.delete();
    while (!stop && trace.size() < max_cycles) begin
      logic [15:0] ins;
      logic [4:0]  opc;
      logic [7:0]  imm;
      int          cls;
      int          lat;
      int          nmem;
      cyc_t        c;
      ins = rom[m_pc];
      opc = ins[15:11];
      imm = ins[7:0];
      cls = op_class(opc);
      trace.push_back(idle_cycle(m_pc));
      m_pc = m_pc + 8'd1;
      trace.push_back(idle_cycle(m_pc));
      if (cls == 6) begin
        push_halt(m_pc, 1'b0);
        stop = 1;
      end else if (cls != 1) begin
        c    = idle_cycle(m_pc);
        c.op = opc;
        trace.push_back(c);
        if (cls == 0) begin
          m_z     = c.flag[0];
          c       = idle_cycle(m_pc);
          c.rf_we = 1'b1;
          c.rd    = ins[10:8];
          trace.push_back(c);
        end else if (cls == 4) begin
          m_pc = imm;
        end else if (cls == 5) begin
          if (m_z) m_pc = imm;
        end else begin
          lat  = pick_latency();
          nmem = (lat < T) ? lat : T;
          for (int k = 1; k <= nmem; k++) begin
            c        = idle_cycle(m_pc);
            c.dm_req = 1'b1;
            c.dm_we  = (cls == 3);
            c.rdy    = (k == lat);
            trace.push_back(c);
          end
          if (lat > T) begin
            push_halt(m_pc, 1'b1);
            stop = 1;
          end else if (cls == 2) begin
            c       = idle_cycle(m_pc);
            c.rf_we = 1'b1;
            c.rd    = ins[10:8];
            trace.push_back(c);
          end
        end
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_pc"},     16'(pc_out),     16'h0000);
    checkOutput({tag, "_op"},     16'(bus.op_dec), 16'h0000);
    checkOutput({tag, "_rf_we"},  16'(bus.rf_we),  16'h0000);
    checkOutput({tag, "_dm_req"}, 16'(bus.dm_req), 16'h0000);
    checkOutput({tag, "_dm_we"},  16'(bus.dm_we),  16'h0000);
    checkOutput({tag, "_halted"}, 16'(halted),     16'h0000);
    checkOutput({tag, "_fault"},  16'(fault),      16'h0000);
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    reset        = 1'b0;
    bus.dm_ready = 1'b0;
    bus.flag_ex  = 4'h0;
    #1;
    check_reset_values("rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_trace(input int n);
    for (int i = 0; i < n && i < trace.size(); i++) begin
      cyc_t c;
      c            = trace[i];
      bus.flag_ex  = c.flag;
      bus.dm_ready = c.rdy;
      #1;
      checkOutput($sformatf("pc@%0d", i),     16'(pc_out),     16'(c.pc));
      checkOutput($sformatf("op@%0d", i),     16'(bus.op_dec), 16'(c.op));
      checkOutput($sformatf("rf_we@%0d", i),  16'(bus.rf_we),  16'(c.rf_we));
      checkOutput($sformatf("dm_req@%0d", i), 16'(bus.dm_req), 16'(c.dm_req));
      checkOutput($sformatf("dm_we@%0d", i),  16'(bus.dm_we),  16'(c.dm_we));
      checkOutput($sformatf("halted@%0d", i), 16'(halted),     16'(c.halted));
      checkOutput($sformatf("fault@%0d", i),  16'(fault),      16'(c.fault));
      if (c.rf_we) checkOutput($sformatf("rd@%0d", i), 16'(bus.rd_addr), 16'(c.rd));
      @(negedge clk);
    end
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = rand_instr();
  endtask

  initial begin
    bus.flag_ex  = 4'h0;
    bus.dm_ready = 1'b0;

    // ALU, BZ and a JMP/NOP pair that wraps the PC past 0xFF
    fill_rom();
    rom[8'h00] = {5'b00001, 3'd1, 8'h00};
    rom[8'h01] = {5'b11001, 3'd0, 8'h40};
    rom[8'h02] = {5'b11000, 3'd0, 8'hFF};
    rom[8'h40] = {5'b11000, 3'd0, 8'hFF};
    rom[8'hFF] = 16'h0000;
    applyStimulus();
    gen_trace(80);
    run_trace(80);

    // LOAD at 0x10 with three MEM cycles, then HLT
    force_lat  = 3;
    rom[8'h00] = {5'b11000, 3'd0, 8'h10};
    rom[8'h10] = {5'b10100, 3'd3, 8'h55};
    rom[8'h11] = 16'hF800;
    applyStimulus();
    gen_trace(40);
    run_trace(40);

    // STORE that never completes, and one completing on the last allowed cycle
    force_lat  = T + 1;
    rom[8'h00] = {5'b10101, 3'd0, 8'h20};
    applyStimulus();
    gen_trace(40);
    run_trace(40);
    force_lat  = T;
    rom[8'h01] = 16'hF800;
    applyStimulus();
    gen_trace(40);
    run_trace(40);

    // Reset pulled low in the middle of a LOAD access
    force_lat  = T + 5;
    rom[8'h00] = {5'b10100, 3'd2, 8'h33};
    applyStimulus();
    gen_trace(10);
    run_trace(4);
    bus.dm_ready = 1'b0;
    #1;
    checkOutput("midmem_req_before", 16'(bus.dm_req), 16'h0001);
    reset = 1'b0;
    #1;
    check_reset_values("midmem");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("midmem_rf_we%0d", k), 16'(bus.rf_we), 16'h0000);
    end
    force_lat = 0;

    repeat (40) begin
      fill_rom();
      applyStimulus();
      gen_trace(250);
      run_trace(250);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
